// File: rtl/c1_wait_ctrl.sv
// ============================================================================
// Module   : c1_wait_ctrl
// Purpose  : 68k wait-state sequencer with DTACK/BERR generation (C1 I/O)
// Revision : 1.0
// ============================================================================
`default_nettype none

module c1_wait_ctrl #(
  parameter int CARD_WAITS     = 2,
  parameter int SROM_WAITS     = 0,
  parameter int ROM_SLOW_WAITS = 1,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic CLK_68KCLK,
  input  logic nRESET,
  input  logic nAS,
  input  logic nROM_ZONE,
  input  logic nPORT_ZONE,
  input  logic nCARD_ZONE,
  input  logic nSROM_ZONE,
  input  logic nROMWAIT,
  input  logic nPWAIT0,
  input  logic nPWAIT1,
  input  logic PDTACK,
  output logic nDTACK,
  output logic nBERR,
  output logic BUSY
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_ACK   = 2'd2,
    S_BERR  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic       port_q, port_d;
  logic [2:0] zone_wait;
  logic       zone_port;
  logic       ack_due;

  // Zone decode with fixed priority ROM > PORT > CARD > SROM
  always_comb begin
    zone_wait = 3'd0;
    zone_port = 1'b0;
    if (!nROM_ZONE) begin
      zone_wait = nROMWAIT ? 3'd0 : 3'(ROM_SLOW_WAITS);
    end else if (!nPORT_ZONE) begin
      zone_wait = {1'b0, ~nPWAIT1, ~nPWAIT0};
      zone_port = 1'b1;
    end else if (!nCARD_ZONE) begin
      zone_wait = 3'(CARD_WAITS);
    end else if (!nSROM_ZONE) begin
      zone_wait = 3'(SROM_WAITS);
    end
  end

  assign ack_due = (cnt_q <= 3'd1) && !(port_q && !PDTACK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    port_d  = port_q;
    case (state_q)
      S_IDLE: begin
        if (!nAS) begin
          port_d = zone_port;
          if (zone_wait == 3'd0 && (!zone_port || PDTACK)) begin
            state_d = S_ACK;
          end else begin
            state_d = S_COUNT;
            cnt_d   = zone_wait;
            tmo_d   = 8'd1;
          end
        end
      end
      S_COUNT: begin
        if (nAS) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
          tmo_d   = 8'd0;
        end else if (ack_due) begin
          state_d = S_ACK;
          cnt_d   = 3'd0;
          tmo_d   = 8'd0;
        end else if (tmo_q >= TIMEOUT_LIMIT) begin
          state_d = S_BERR;
          cnt_d   = 3'd0;
          tmo_d   = 8'd0;
        end else begin
          if (cnt_q > 3'd1) cnt_d = cnt_q - 3'd1;
          if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
        end
      end
      S_ACK, S_BERR: begin
        if (nAS) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs registered from the next state so they change cleanly on the edge
  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      tmo_q   <= 8'd0;
      port_q  <= 1'b0;
      nDTACK  <= 1'b1;
      nBERR   <= 1'b1;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      port_q  <= port_d;
      nDTACK  <= (state_d != S_ACK);
      nBERR   <= (state_d != S_BERR);
      BUSY    <= (state_d == S_COUNT);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_c1_wait_ctrl.sv
// ============================================================================
// Module   : tb_c1_wait_ctrl
// Purpose  : Self-checking bench for c1_wait_ctrl (directed + randomized)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_c1_wait_ctrl;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic as_n = 1'b1, rom_n = 1'b1, port_n = 1'b1, card_n = 1'b1, srom_n = 1'b1;
  logic romwait_n = 1'b1, pw0_n = 1'b1, pw1_n = 1'b1, pdtack = 1'b0;
  wire  dtack_n, berr_n, busy;

  always #5 clk = ~clk;

  c1_wait_ctrl #(
    .CARD_WAITS    (2),
    .SROM_WAITS    (0),
    .ROM_SLOW_WAITS(1),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .CLK_68KCLK(clk),
    .nRESET    (rst_n),
    .nAS       (as_n),
    .nROM_ZONE (rom_n),
    .nPORT_ZONE(port_n),
    .nCARD_ZONE(card_n),
    .nSROM_ZONE(srom_n),
    .nROMWAIT  (romwait_n),
    .nPWAIT0   (pw0_n),
    .nPWAIT1   (pw1_n),
    .PDTACK    (pdtack),
    .nDTACK    (dtack_n),
    .nBERR     (berr_n),
    .BUSY      (busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait clocks of the highest-priority selected zone
  function automatic int zone_wait_of(input logic r, p, c, s, rw, w1, w0);
    if (!r) return rw ? 0 : 1;
    if (!p) return (w1 ? 0 : 2) + (w0 ? 0 : 1);
    if (!c) return 2;
    if (!s) return 0;
    return 0;
  endfunction

  // Cycle-level model: a cycle starting at edge k acks at the first edge
  // e >= k+W where the port handshake (if any) is present, errors at k+TO,
  // and aborts on any edge that sees the strobe released.
  int e = 0, k = 0, w = 0, mode = 0;  // 0 idle, 1 waiting, 2 acked, 3 errored
  bit mport = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mode = 0;
    end else begin
      case (mode)
        0: if (!as_n) begin
             k = e;
             w = zone_wait_of(rom_n, port_n, card_n, srom_n, romwait_n, pw1_n, pw0_n);
             mport = rom_n && !port_n;
             mode = (!mport || pdtack) && (w == 0) ? 2 : 1;
           end
        1: if (as_n) mode = 0;
           else if ((e - k >= w) && (!mport || pdtack)) mode = 2;
           else if (e - k >= TO) mode = 3;
        default: if (as_n) mode = 0;
      endcase
    end
    e++;
    #1;
    chk("model_dtack", dtack_n, (mode != 2));
    chk("model_berr", berr_n, (mode != 3));
    chk("model_busy", busy, (mode == 1));
    chk("never_both_low", (!dtack_n && !berr_n), 0);
  end

  task automatic set_zone(input logic r, p, c, s, rw, w1, w0);
    rom_n = r; port_n = p; card_n = c; srom_n = s;
    romwait_n = rw; pw1_n = w1; pw0_n = w0;
  endtask

  // Starts a cycle; PDTACK is high from edge pd_rise on. Returns edges until ack/error.
  task automatic measure(input int pd_rise, output int lat, output bit err);
    lat = -1;
    err = 1'b0;
    @(negedge clk);
    as_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pdtack = (i >= pd_rise);
      @(posedge clk);
      #1;
      if (!dtack_n || !berr_n) begin
        lat = i;
        err = !berr_n;
        break;
      end
    end
  endtask

  task automatic release_check(input string name);
    @(negedge clk);
    as_n = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_rel_dtack"}, dtack_n, 1);
    chk({name, "_rel_berr"}, berr_n, 1);
  endtask

  int lat;
  bit err;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dtack", dtack_n, 1);
    chk("reset_berr", berr_n, 1);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unmapped: immediate ack, held until strobe released at edge 3
    set_zone(1, 1, 1, 1, 1, 1, 1);
    measure(999, lat, err);
    chk("unmapped_lat", lat, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("unmapped_hold", dtack_n, 0);
    end
    release_check("unmapped");

    set_zone(0, 1, 1, 1, 0, 1, 1);
    measure(0, lat, err);
    chk("rom_slow_lat", lat, 1);
    release_check("rom_slow");

    set_zone(0, 1, 1, 1, 1, 1, 1);
    measure(0, lat, err);
    chk("rom_fast_lat", lat, 0);
    release_check("rom_fast");

    set_zone(1, 0, 1, 1, 1, 0, 1);
    measure(5, lat, err);
    chk("port_pdlate_lat", lat, 5);
    release_check("port_pdlate");

    set_zone(1, 0, 1, 1, 1, 0, 1);
    measure(0, lat, err);
    chk("port_pdhigh_lat", lat, 2);
    release_check("port_pdhigh");

    set_zone(1, 0, 1, 1, 1, 0, 1);
    measure(999, lat, err);
    chk("timeout_lat", lat, 8);
    chk("timeout_is_berr", err, 1);
    chk("timeout_dtack", dtack_n, 1);
    release_check("timeout");

    // Card cycle aborted before its ack edge
    set_zone(1, 1, 0, 1, 1, 1, 1);
    @(negedge clk);
    as_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_e0", busy, 1);
    @(posedge clk);
    #1;
    chk("abort_dtack_e1", dtack_n, 1);
    as_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_dtack_e2", dtack_n, 1);
    chk("abort_busy_e2", busy, 0);

    // Asynchronous reset in the middle of a card wait
    @(negedge clk);
    as_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_dtack", dtack_n, 1);
    chk("rstmid_busy", busy, 0);
    as_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ROM beats PORT even with port waits and no PDTACK
    set_zone(0, 0, 1, 1, 1, 0, 0);
    measure(999, lat, err);
    chk("prio_rom_lat", lat, 0);
    release_check("prio_rom");

    // Randomized traffic; the model process checks every edge
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      as_n      = ($urandom_range(0, 9) < 3);
      rom_n     = ($urandom_range(0, 3) != 0);
      port_n    = ($urandom_range(0, 2) != 0);
      card_n    = $urandom_range(0, 1);
      srom_n    = $urandom_range(0, 1);
      romwait_n = $urandom_range(0, 1);
      pw0_n     = $urandom_range(0, 1);
      pw1_n     = $urandom_range(0, 1);
      pdtack    = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    as_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/c1_wait_ctrl.md
Name: c1_wait_ctrl

Overview:
- Per-cycle wait-state sequencer and DTACK/BERR generator for the 68k bus in the C1 I/O section.
- Decodes the active address zone on each bus cycle and loads a zone-specific wait count.
- Counts the wait count down, then holds nDTACK low until the 68k ends the cycle.
- Port-zone cycles also wait for the cartridge PDTACK handshake. A watchdog raises nBERR on cycles that never complete.

Parameters:
CARD_WAITS, 2, wait clocks for memory-card zone (0-7)
SROM_WAITS, 0, wait clocks for system-ROM zone (0-7)
ROM_SLOW_WAITS, 1, wait clocks for ROM zone when nROMWAIT=0 (0-7)
TIMEOUT_CYC, 255, CLK_68KCLK edges with nAS low and no ack before nBERR (1-255)

Ports:
CLK_68KCLK  in  1  68k clock; all state changes on posedge
nRESET  in  1  asynchronous active-low reset
nAS  in  1  68k address strobe, active low
nROM_ZONE  in  1  P-ROM zone select, active low
nPORT_ZONE  in  1  cartridge port zone select, active low
nCARD_ZONE  in  1  memory-card zone select, active low
nSROM_ZONE  in  1  system-ROM zone select, active low
nROMWAIT  in  1  0 = ROM zone needs ROM_SLOW_WAITS, 1 = 0 waits
nPWAIT0  in  1  port wait bit 0, active low
nPWAIT1  in  1  port wait bit 1, active low
PDTACK  in  1  cartridge port ready, active high
nDTACK  out  1  registered data acknowledge to 68k
nBERR  out  1  registered bus error to 68k
BUSY  out  1  high while a cycle is decoded and not yet acked/errored

Behaviour:
- Reset (async, nRESET=0):
  - state IDLE, nDTACK=1, nBERR=1, BUSY=0.
  - Wait and timeout counters cleared.
  - Reset mid-cycle aborts immediately; no ack.
- States: IDLE, COUNT, ACK, BERR.
- Zone priority: ROM > PORT > CARD > SROM > none.
- Wait value W per zone (3-bit):
  - ROM: ROM_SLOW_WAITS if nROMWAIT=0, else 0.
  - PORT: {~nPWAIT1,~nPWAIT0} (0-3).
  - CARD: CARD_WAITS.
  - SROM: SROM_WAITS.
  - none: 0, no PDTACK requirement.
- Zone, W and port flag are latched once, on the edge where IDLE samples nAS=0 (edge k). Later zone or wait input changes are ignored until IDLE.
- IDLE, nAS=0 at edge k:
  - W=0 and (not port zone or PDTACK=1): go to ACK, nDTACK=0 after edge k.
  - Otherwise: go to COUNT, cnt=W, BUSY=1, timeout counter=1.
- COUNT at each edge:
  - nAS=1: abort to IDLE; nDTACK and nBERR stay 1.
  - Else if cnt>1: cnt-1.
  - Else if port zone and PDTACK=0: hold.
  - Else: go to ACK, nDTACK=0.
  - Net latency with PDTACK high: nDTACK low after edge k+W, i.e. W extra clocks.
- PDTACK is sampled at every COUNT edge, with no synchroniser in this block.
- Timeout:
  - Counter increments each COUNT edge.
  - Reaching TIMEOUT_CYC at an edge where ack is not due: go to BERR, nBERR=0, nDTACK stays 1.
  - If ack and timeout are due on the same edge, ack wins.
- ACK and BERR:
  - Outputs held; BUSY=0.
  - The edge sampling nAS=1 returns to IDLE and sets nDTACK=1, nBERR=1.
- Back-to-back cycles: from IDLE, a new nAS=0 is accepted on the next edge. No dead cycle beyond the one IDLE edge.
- nDTACK and nBERR are never low simultaneously.
- Counters saturate and never wrap.

Test Plan:
- Unmapped, nAS low at edge 0 -> nDTACK=0 after edge 0; nAS high at edge 3 -> nDTACK=1 after edge 3.
- ROM zone, nROMWAIT=0, ROM_SLOW_WAITS=1 -> nDTACK low after edge 1. With nROMWAIT=1 -> low after edge 0.
- Port zone, nPWAIT1=0, nPWAIT0=1 (W=2), PDTACK held low until edge 5 -> nDTACK low after edge 5, not 2. With PDTACK=1 throughout -> low after edge 2.
- Port zone, PDTACK stuck 0, TIMEOUT_CYC=8 -> nBERR=0 after edge 8, nDTACK stays 1; release nAS -> both 1 next edge.
- CARD zone (W=2), nAS released after edge 1 -> no nDTACK pulse, state IDLE. nRESET pulsed low mid-COUNT -> nDTACK=1, BUSY=0 immediately.
- ROM and PORT both low with nPWAIT=00 (W=3), nROMWAIT=1 -> ROM wins, nDTACK low after edge 0.
